// File: rtl/state_scan_pkg.sv
// state_scan_pkg: shared types, sizes and word selection for the two-copy state scanner
package state_scan_pkg;
  localparam int XLEN_C = 32;
  localparam int NUM_REGS_C = 32;
  localparam int PC_IDX_C = NUM_REGS_C;
  localparam int NUM_WORDS_C = NUM_REGS_C + 1;
  localparam int IDX_W_C = 6;
  typedef enum logic [1:0] {IDLE, FREEZE, SCAN, DONE} scan_state_e;
  function automatic logic [XLEN_C-1:0] word_sel(input logic [NUM_WORDS_C*XLEN_C-1:0] flat,
                                                 input logic [IDX_W_C-1:0] idx);
    return flat[idx*XLEN_C +: XLEN_C];
  endfunction
endpackage

// File: rtl/state_word_mux.sv
// state_word_mux: picks word idx of one copy's flat state (regfile words, then pc at PC_IDX_C)
module state_word_mux
  import state_scan_pkg::*;
(
  input  logic [NUM_REGS_C*XLEN_C-1:0] regfile_flat,
  input  logic [XLEN_C-1:0]            pc,
  input  logic [IDX_W_C-1:0]           idx,
  output logic [XLEN_C-1:0]            word
);
  assign word = word_sel({pc, regfile_flat}, idx);
endmodule

// File: rtl/state_scan_ctrl.sv
// state_scan_ctrl: freezes both cores and compares their flattened state word by word.
// Define STATE_SCAN_DUMP_EN to stream copy A words out through a valid/ready dump port.
module state_scan_ctrl
  import state_scan_pkg::*;
#(
  parameter int FREEZE_TIMEOUT = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          core_stalled,
  input  logic [NUM_REGS_C*XLEN_C-1:0]  regfile_a_flat,
  input  logic [NUM_REGS_C*XLEN_C-1:0]  regfile_b_flat,
  input  logic [XLEN_C-1:0]             pc_a,
  input  logic [XLEN_C-1:0]             pc_b,
  input  logic                          dump_ready,
  output logic                          core_stall_req,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          mismatch,
  output logic [IDX_W_C-1:0]            mismatch_idx,
  output logic [IDX_W_C-1:0]            mismatch_cnt,
  output logic                          dump_valid,
  output logic [IDX_W_C-1:0]            dump_idx,
  output logic [XLEN_C-1:0]             dump_data
);
  localparam int TO_W = $clog2(FREEZE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FREEZE_TIMEOUT);
  localparam logic [IDX_W_C-1:0] IDX_LAST = IDX_W_C'(NUM_WORDS_C - 1);
  scan_state_e state, state_nx;
  logic [IDX_W_C-1:0] idx;
  logic [TO_W-1:0] tcnt;
  logic [XLEN_C-1:0] word_a, word_b;
  logic step, diff, timeout, lost;
  state_word_mux u_mux_a (.regfile_flat(regfile_a_flat), .pc(pc_a), .idx(idx), .word(word_a));
  state_word_mux u_mux_b (.regfile_flat(regfile_b_flat), .pc(pc_b), .idx(idx), .word(word_b));
  assign diff = word_a != word_b;
`ifdef STATE_SCAN_DUMP_EN
  assign dump_valid = state == SCAN;
  assign dump_idx = dump_valid ? idx : '0;
  assign dump_data = dump_valid ? word_a : '0;
  assign step = dump_valid && dump_ready;
`else
  logic unused_dump_ready;
  assign unused_dump_ready = dump_ready;
  assign dump_valid = 1'b0;
  assign dump_idx = '0;
  assign dump_data = '0;
  assign step = state == SCAN;
`endif
  assign timeout = state == FREEZE && !core_stalled && tcnt == TO_LAST;
  assign lost = state == SCAN && !core_stalled;
  assign core_stall_req = state == FREEZE || state == SCAN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? FREEZE : IDLE) :
               state == FREEZE ? (core_stalled ? SCAN : timeout ? DONE : FREEZE) :
               state == SCAN ? ((lost || (step && idx == IDX_LAST)) ? DONE : SCAN) :
               IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      tcnt <= '0;
      aborted <= 1'b0;
      mismatch <= 1'b0;
      mismatch_idx <= '0;
      mismatch_cnt <= '0;
    end else begin
      state <= state_nx;
      tcnt <= state == FREEZE ? tcnt + 1'b1 : '0;
      if (state == FREEZE) idx <= '0;
      if (state == IDLE && start) begin
        aborted <= 1'b0;
        mismatch <= 1'b0;
        mismatch_idx <= '0;
        mismatch_cnt <= '0;
      end
      if (timeout || lost) aborted <= 1'b1;
      // a dropped ack takes priority, so the word under scan is not counted
      if (state == SCAN && core_stalled && step) begin
        idx <= idx + 1'b1;
        if (diff) begin
          mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!mismatch) begin
            mismatch <= 1'b1;
            mismatch_idx <= idx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_state_scan_ctrl.sv
// tb_state_scan_ctrl: table-driven scans with a result scoreboard, plus reset and dump sequences
module tb_state_scan_ctrl;
  logic clock = 1'b0;
  logic reset, start, dump_ready, ack_auto, ack_val, core_stalled;
  logic [32*32-1:0] regfile_a_flat, regfile_b_flat;
  logic [31:0] pc_a, pc_b;
  logic core_stall_req, busy, done, aborted, mismatch, dump_valid;
  logic [5:0] mismatch_idx, mismatch_cnt, dump_idx;
  logic [31:0] dump_data;
  int total = 0, bad = 0;

  typedef struct {
    logic [32:0] dmask;
    logic        ack;
    int          drop;
    logic        em;
    logic [5:0]  ei;
    logic [5:0]  ec;
    logic        ea;
    int          ecyc;
  } vec_t;
  vec_t tbl[6];
  vec_t exp_q[$];

  always #5 clock = ~clock;
  assign core_stalled = ack_auto ? core_stall_req : ack_val;

  state_scan_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .core_stalled(core_stalled),
    .regfile_a_flat(regfile_a_flat), .regfile_b_flat(regfile_b_flat),
    .pc_a(pc_a), .pc_b(pc_b), .dump_ready(dump_ready),
    .core_stall_req(core_stall_req), .busy(busy), .done(done), .aborted(aborted),
    .mismatch(mismatch), .mismatch_idx(mismatch_idx), .mismatch_cnt(mismatch_cnt),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [32:0] dmask);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      regfile_a_flat[i*32 +: 32] = w;
      regfile_b_flat[i*32 +: 32] = dmask[i] ? ~w : w;
    end
    pc_a = $urandom;
    pc_b = dmask[32] ? ~pc_a : pc_a;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " stall_req"}, core_stall_req, 0);
    chk({tag, " aborted"}, aborted, 0);
    chk({tag, " mismatch"}, mismatch, 0);
    chk({tag, " mismatch_idx"}, mismatch_idx, 0);
    chk({tag, " mismatch_cnt"}, mismatch_cnt, 0);
    chk({tag, " dump_valid"}, dump_valid, 0);
    chk({tag, " dump_idx"}, dump_idx, 0);
    chk({tag, " dump_data"}, dump_data, 0);
  endtask

  task automatic run_scan(input vec_t v);
    vec_t e;
    int cyc;
    bit seen;
    load(v.dmask);
    ack_auto = v.ack;
    ack_val = 1'b0;
    dump_ready = 1'b1;
    exp_q.push_back(v);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    seen = 0;
    for (cyc = 1; cyc < 400; cyc++) begin
      @(negedge clock);
      start = (cyc == 7);
      if (v.drop >= 0 && cyc == v.drop + 2) begin
        ack_auto = 1'b0;
        ack_val = 1'b0;
      end
`ifndef STATE_SCAN_DUMP_EN
      if (cyc == 7) begin
        chk("dump_valid tied", dump_valid, 0);
        chk("dump_data tied", dump_data, 0);
      end
`endif
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clock);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk("done seen", seen, 1);
    chk("done cycle", cyc, e.ecyc);
    chk("mismatch", mismatch, e.em);
    chk("mismatch_idx", mismatch_idx, e.ei);
    chk("mismatch_cnt", mismatch_cnt, e.ec);
    chk("aborted", aborted, e.ea);
    chk("stall_req in done", core_stall_req, 0);
    @(negedge clock);
    chk("done pulse width", done, 0);
    chk("busy after done", busy, 0);
    chk("stall_req after done", core_stall_req, 0);
    chk("aborted held", aborted, e.ea);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{33'h0, 1'b1, -1, 1'b0, 6'd0, 6'd0, 1'b0, 35};
    tbl[1] = '{(33'h1 << 5) | (33'h1 << 17) | (33'h1 << 32), 1'b1, -1, 1'b1, 6'd5, 6'd3, 1'b0, 35};
    tbl[2] = '{33'h1, 1'b1, -1, 1'b1, 6'd0, 6'd1, 1'b0, 35};
    tbl[3] = '{{33{1'b1}}, 1'b1, -1, 1'b1, 6'd0, 6'd33, 1'b0, 35};
    tbl[4] = '{(33'h1 << 3) | (33'h1 << 12), 1'b1, 10, 1'b1, 6'd3, 6'd1, 1'b1, 13};
    tbl[5] = '{33'h10, 1'b0, -1, 1'b0, 6'd0, 6'd0, 1'b1, 257};
    reset = 1'b1;
    start = 1'b0;
    dump_ready = 1'b0;
    ack_auto = 1'b1;
    ack_val = 1'b0;
    load(33'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    reset = 1'b0;

    foreach (tbl[i]) run_scan(tbl[i]);

    // reset in the middle of a scan that has already seen a mismatch
    load((33'h1 << 2) | (33'h1 << 25));
    ack_auto = 1'b1;
    dump_ready = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int c = 1; c < 22; c++) begin
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    chk("pre-reset mismatch", mismatch, 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_idle("mid reset");
    reset = 1'b0;
    run_scan('{33'h1 << 25, 1'b1, -1, 1'b1, 6'd25, 6'd1, 1'b0, 35});

`ifdef STATE_SCAN_DUMP_EN
    begin
      logic [37:0] dq[$];
      logic [37:0] got, hold;
      bit have_hold, fin;
      int beats;
      load(33'h0);
      ack_auto = 1'b1;
      dump_ready = 1'b0;
      for (int i = 0; i < 33; i++)
        dq.push_back({6'(i), i < 32 ? regfile_a_flat[i*32 +: 32] : pc_a});
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      beats = 0;
      have_hold = 0;
      fin = 0;
      for (int c = 0; c < 200 && !fin; c++) begin
        @(negedge clock);
        start = 1'b0;
        got = {dump_idx, dump_data};
        if (dump_valid) begin
          if (have_hold) chk("dump stable", got, hold);
          have_hold = 0;
          if (dump_ready) begin
            beats++;
            if (dq.size() > 0) chk("dump beat", got, dq.pop_front());
            else chk("dump extra beat", got, 38'h0);
          end else begin
            hold = got;
            have_hold = 1;
          end
        end
        fin = done;
        dump_ready = ~dump_ready;
        if (!fin) @(posedge clock);
      end
      chk("dump done seen", fin, 1);
      chk("dump beats", beats, 33);
      chk("dump mismatch", mismatch, 0);
      chk("dump aborted", aborted, 0);
      @(negedge clock);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
